// File: rtl/key_cmd_pkg.sv
// key_cmd_pkg: scan-code constants, command encodings and decode helpers
// shared by the keyboard command queue.
package key_cmd_pkg;
   typedef enum logic [2:0] {
      CMD_NONE   = 3'd0,
      CMD_UP     = 3'd1,
      CMD_DOWN   = 3'd2,
      CMD_LEFT   = 3'd3,
      CMD_RIGHT  = 3'd4,
      CMD_SELECT = 3'd5,
      CMD_ESCAPE = 3'd6
   } cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } dec_state_t;

   localparam logic [7:0] SC_EXT     = 8'hE0;
   localparam logic [7:0] SC_BRK     = 8'hF0;
   localparam logic [7:0] SC_W       = 8'h1D;
   localparam logic [7:0] SC_S       = 8'h1B;
   localparam logic [7:0] SC_A       = 8'h1C;
   localparam logic [7:0] SC_D       = 8'h23;
   localparam logic [7:0] SC_SPACE   = 8'h29;
   localparam logic [7:0] SC_ESC     = 8'h76;
   localparam logic [7:0] SC_A_UP    = 8'h75;
   localparam logic [7:0] SC_A_DOWN  = 8'h72;
   localparam logic [7:0] SC_A_LEFT  = 8'h6B;
   localparam logic [7:0] SC_A_RIGHT = 8'h74;

   // Plain (non-prefixed) make codes. Keypad arrows without E0 are not mapped.
   function automatic cmd_t map_make(input logic [7:0] code);
      case (code)
         SC_W:     return CMD_UP;
         SC_S:     return CMD_DOWN;
         SC_A:     return CMD_LEFT;
         SC_D:     return CMD_RIGHT;
         SC_SPACE: return CMD_SELECT;
         SC_ESC:   return CMD_ESCAPE;
         default:  return CMD_NONE;
      endcase
   endfunction

   // Make codes that follow an E0 prefix: only the cursor arrows are mapped.
   function automatic cmd_t map_ext(input logic [7:0] code);
      case (code)
         SC_A_UP:    return CMD_UP;
         SC_A_DOWN:  return CMD_DOWN;
         SC_A_LEFT:  return CMD_LEFT;
         SC_A_RIGHT: return CMD_RIGHT;
         default:    return CMD_NONE;
      endcase
   endfunction
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: small synchronous FIFO for decoded commands.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_push/i_data write side;
// i_pop read request (ignored when empty); o_data head (0 when empty);
// o_full/o_empty/o_count occupancy status.
module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 3
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic                   i_push,
   input  logic [W-1:0]           i_data,
   input  logic                   i_pop,
   output logic [W-1:0]           o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_pop;
   logic          w_push;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_count = r_count;
   assign o_data  = o_empty ? '0 : r_mem[r_rptr];
   assign w_pop   = i_pop & ~o_empty;
   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign w_push  = i_push & (~o_full | w_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop) r_rptr <= r_rptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end
endmodule

// File: rtl/key_cmd_queue.sv
// key_cmd_queue: PS/2 set-2 scan-code decoder feeding a command FIFO.
// Ports: CLK clock; RST async active-low reset; kb_strobe/kb_code incoming byte;
// cmd_valid/cmd_ready/cmd head-of-queue handshake; fifo_count occupancy;
// overflow sticky flag set when a decoded command is dropped on a full FIFO.
module key_cmd_queue
   import key_cmd_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   kb_strobe,
   input  logic [7:0]             kb_code,
   output logic                   cmd_valid,
   input  logic                   cmd_ready,
   output logic [2:0]             cmd,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   overflow
);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   dec_state_t    r_state;
   dec_state_t    w_next;
   cmd_t          w_cmd;
   logic          w_push;
   logic          w_full;
   logic          w_empty;
   logic          w_timeout;
   logic [TW-1:0] r_to_cnt;
   logic          r_ovf;

   // A prefix left hanging for TIMEOUT_CYC strobe-free cycles is abandoned.
   assign w_timeout = (r_state != ST_IDLE) & ~kb_strobe & (r_to_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) r_state <= ST_IDLE;
      else r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_timeout) w_next = ST_IDLE;
      else if (kb_strobe) begin
         case (r_state)
            ST_IDLE: w_next = (kb_code == SC_EXT) ? ST_EXT : (kb_code == SC_BRK) ? ST_BRK : ST_IDLE;
            ST_EXT:  w_next = (kb_code == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
            default: w_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_cmd  = (r_state == ST_IDLE) ? map_make(kb_code) : (r_state == ST_EXT) ? map_ext(kb_code) : CMD_NONE;
      w_push = kb_strobe & (w_cmd != CMD_NONE);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) r_to_cnt <= '0;
      else if (kb_strobe | (r_state == ST_IDLE) | w_timeout) r_to_cnt <= '0;
      else r_to_cnt <= r_to_cnt + TW'(1);
   end

   // When full the FIFO is non-empty, so cmd_ready alone tells whether a pop frees a slot.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) r_ovf <= 1'b0;
      else if (w_push & w_full & ~cmd_ready) r_ovf <= 1'b1;
   end

   cmd_fifo #(.DEPTH(DEPTH), .W(3)) u_fifo (
      .i_clk   (CLK),
      .i_rst_n (RST),
      .i_push  (w_push),
      .i_data  (w_cmd),
      .i_pop   (cmd_ready),
      .o_data  (cmd),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (fifo_count)
   );

   assign cmd_valid = ~w_empty;
   assign overflow  = r_ovf;
endmodule
